// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word SRAM between instruction fetch and data load/store ports.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_MAX denials.
module mem_port_arbiter #(
  parameter int MEM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_re,
  input  logic [31:0]       d_raddr,
  output logic              d_rgnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              d_we,
  input  logic [31:0]       d_waddr,
  input  logic [31:0]       d_wdata,
  output logic              d_wgnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {G_NONE, G_IF, G_DR, G_DW} gnt_t;
  gnt_t          last_gnt;
  logic [CW-1:0] starve_cnt;
  logic          force_if;
  logic          unused_bits;
  // Grants are gated by rst_n so every output is quiet the moment reset asserts.
  always_comb begin
    force_if  = rst_n && if_req && starve_cnt == CW'(STARVE_MAX);
    d_wgnt    = rst_n && !force_if && d_we;
    d_rgnt    = rst_n && !force_if && !d_we && d_re;
    if_gnt    = rst_n && if_req && (force_if || (!d_we && !d_re));
    mem_en    = d_wgnt || d_rgnt || if_gnt;
    mem_we    = d_wgnt;
    mem_addr  = d_wgnt ? d_waddr[MEM_AW+1:2] :
                d_rgnt ? d_raddr[MEM_AW+1:2] :
                if_gnt ? if_addr[MEM_AW+1:2] : '0;
    mem_wdata = d_wgnt ? d_wdata : '0;
    if_rvalid = last_gnt == G_IF;
    d_rvalid  = last_gnt == G_DR;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_gnt   <= G_NONE;
      starve_cnt <= '0;
    end else begin
      last_gnt   <= d_wgnt ? G_DW : d_rgnt ? G_DR : if_gnt ? G_IF : G_NONE;
      starve_cnt <= !(if_req && !if_gnt) ? '0 :
                    starve_cnt == CW'(STARVE_MAX) ? starve_cnt : starve_cnt + CW'(1);
    end
  assign unused_bits = ^{if_addr[31:MEM_AW+2], if_addr[1:0], d_raddr[31:MEM_AW+2],
                         d_raddr[1:0], d_waddr[31:MEM_AW+2], d_waddr[1:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration order, latency, starvation and reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_re, d_we;
  logic [31:0] if_addr, d_raddr, d_waddr, d_wdata;
  logic        if_gnt, if_rvalid, d_rgnt, d_rvalid, d_wgnt;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [4096];
  int          n_cmp = 0;
  int          n_err = 0;

  mem_port_arbiter #(.MEM_AW(12), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_re(d_re), .d_raddr(d_raddr), .d_rgnt(d_rgnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_we(d_we), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wgnt(d_wgnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_rdata = '0;
    if_req = 1'b1; d_re = 1'b1; d_we = 1'b1;
    if_addr = 32'h10; d_raddr = 32'h20; d_waddr = 32'h30; d_wdata = 32'h1234;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    #7;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_d_rgnt", 32'(d_rgnt), 0);
    chk("rst_d_wgnt", 32'(d_wgnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalids", {30'b0, if_rvalid, d_rvalid}, 0);
    if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    // fetch only, back to back
    if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_addr = 32'(i * 4);
      #1;
      chk("t1_if_gnt", 32'(if_gnt), 1);
      chk("t1_mem_addr", 32'(mem_addr), 32'(i));
      tick;
      chk("t1_if_rvalid", 32'(if_rvalid), 1);
      chk("t1_if_rdata", if_rdata, 32'h1000_0000 + 32'(i));
    end
    if_req = 1'b0;
    #1 chk("t1_idle_gnt", 32'(if_gnt), 0);
    tick;
    chk("t1_idle_rvalid", 32'(if_rvalid), 0);
    chk("t1_idle_rdata", if_rdata, 0);
    // store and load to the same word in the same cycle
    d_we = 1'b1; d_waddr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    d_re = 1'b1; d_raddr = 32'h100;
    #1;
    chk("t2_d_wgnt", 32'(d_wgnt), 1);
    chk("t2_d_rgnt0", 32'(d_rgnt), 0);
    chk("t2_mem_we", 32'(mem_we), 1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h40);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick;
    d_we = 1'b0;
    chk("t2_no_rvalid_after_store", 32'(d_rvalid), 0);
    #1;
    chk("t2_d_rgnt1", 32'(d_rgnt), 1);
    chk("t2_mem_we0", 32'(mem_we), 0);
    chk("t2_mem_wdata0", mem_wdata, 0);
    tick;
    chk("t2_d_rvalid", 32'(d_rvalid), 1);
    chk("t2_d_rdata", d_rdata, 32'hDEAD_BEEF);
    // unaligned load maps onto the same word
    d_raddr = 32'h103;
    #1;
    chk("t6_d_rgnt", 32'(d_rgnt), 1);
    chk("t6_mem_addr", 32'(mem_addr), 32'h40);
    tick;
    chk("t6_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_re = 1'b0;
    tick;
    // starvation: load held, fetch forced on the 5th cycle then counter restarts
    d_re = 1'b1; d_raddr = 32'h8;
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("t3_if_gnt_c%0d", c), 32'(if_gnt), 32'(c == 4));
      chk($sformatf("t3_d_rgnt_c%0d", c), 32'(d_rgnt), 32'(c != 4));
      tick;
      chk($sformatf("t3_if_rvalid_c%0d", c), 32'(if_rvalid), 32'(c == 4));
      chk($sformatf("t3_rdata_c%0d", c), c == 4 ? if_rdata : d_rdata,
          c == 4 ? 32'h1000_0004 : 32'h1000_0002);
    end
    d_re = 1'b0; if_req = 1'b0;
    tick;
    // all three at once: store, load, fetch
    d_we = 1'b1; d_waddr = 32'h200; d_wdata = 32'hCAFE_F00D;
    d_re = 1'b1; d_raddr = 32'h204;
    if_req = 1'b1; if_addr = 32'hC;
    #1;
    chk("t4_c0_grants", {29'b0, d_wgnt, d_rgnt, if_gnt}, 32'b100);
    chk("t4_c0_mem_en", 32'(mem_en), 1);
    chk("t4_c0_wdata", mem_wdata, 32'hCAFE_F00D);
    tick;
    d_we = 1'b0;
    #1;
    chk("t4_c1_grants", {29'b0, d_wgnt, d_rgnt, if_gnt}, 32'b010);
    chk("t4_c1_mem_en", 32'(mem_en), 1);
    tick;
    d_re = 1'b0;
    chk("t4_d_rdata", d_rdata, 32'h1000_0081);
    #1;
    chk("t4_c2_grants", {29'b0, d_wgnt, d_rgnt, if_gnt}, 32'b001);
    chk("t4_c2_mem_addr", 32'(mem_addr), 32'h3);
    tick;
    if_req = 1'b0;
    chk("t4_if_rvalid", 32'(if_rvalid), 1);
    chk("t4_if_rdata", if_rdata, 32'h1000_0003);
    #1 chk("t4_c3_mem_en", 32'(mem_en), 0);
    tick;
    // reset mid-cycle after a load grant drops the response
    d_re = 1'b1; d_raddr = 32'h0;
    #1 chk("t5_d_rgnt", 32'(d_rgnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_d_rgnt", 32'(d_rgnt), 0);
    chk("t5_rst_mem_en", 32'(mem_en), 0);
    chk("t5_rst_mem_addr", 32'(mem_addr), 0);
    tick;
    chk("t5_d_rvalid", 32'(d_rvalid), 0);
    chk("t5_d_rdata", d_rdata, 0);
    tick;
    chk("t5_d_rvalid2", 32'(d_rvalid), 0);
    d_re = 1'b0;
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h14;
    #1 chk("t5_first_gnt", 32'(if_gnt), 1);
    tick;
    if_req = 1'b0;
    chk("t5_if_rdata", if_rdata, 32'h1000_0005);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
